decrypter_top_level: RTL and testbench

Self-contained LFSR stream decrypter with an embedded 256x8 data memory. A host loads a 64-byte ciphertext block into mem[0:63] and releases init. The block then identifies the 5-bit LFSR tap pattern and seed from the known preamble, writes the decrypted payload to mem[64:127], and raises done. The host reads results back through the same memory port.

---
 rtl/decrypter_top_level.sv | 259 +++++++++++++++++++++++++
 tb/tb_decrypter_top_level.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypter_top_level.sv
// ============================================================================
// Module   : decrypter_top_level (with embedded memory dm1)
// Purpose  : 5-bit LFSR stream decrypter. Recovers the tap pattern and seed
//            from a known preamble held in mem[0..MSG_LEN-1]. Writes the
//            decrypted payload to mem[64..], then raises done.
// Options  : TAIL_FILL_EN - when defined, the output tail left unused by the
//            payload (mem[64+MSG_LEN-pre_len .. 64+MSG_LEN-1]) is filled with
//            the preamble value before done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm1 (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  // Storage has no reset: contents survive init so the host can read results.
  logic [7:0] core [0:255];

  // Single synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      core[waddr] <= wdata;
    end
  end

  assign rdata = core[raddr];

endmodule

module decrypter_top_level #(
  parameter int MSG_LEN = 64,
  parameter int LFSR_W  = 5
) (
  input  logic       clk,
  input  logic       init,
  input  logic [7:0] preamble,
  input  logic [7:0] pre_len,
  input  logic       wr_en_tb,
  input  logic [7:0] waddr_tb,
  input  logic [7:0] data_in_tb,
  input  logic [7:0] raddr_tb,
  output logic [7:0] data_out_tb,
  input  logic       mem_tb_control,
  output logic       done
);

  localparam int OUT_BASE = 64;
  // Fallback path fast-forwards the LFSR combinationally over the preamble;
  // this bounds the unrolled depth to the largest legal pre_len.
  localparam int MAX_ADV  = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_SEARCH  = 3'd2,
    ST_DECRYPT = 3'd3,
    ST_TAIL    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic [2:0]        pat_q, pat_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        k_q, k_d;

  logic [7:0] fsm_raddr, fsm_waddr, fsm_wdata;
  logic       fsm_we;
  logic [7:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic       mem_we;

  logic [7:0] ks_byte;
  logic       byte_match;
  logic       search_last;
  logic       decrypt_avail;

  function automatic logic [LFSR_W-1:0] taps_of(input logic [2:0] p);
    logic [LFSR_W-1:0] t;
    case (p)
      3'd0:    t = LFSR_W'(5'h1E);
      3'd1:    t = LFSR_W'(5'h1D);
      3'd2:    t = LFSR_W'(5'h1B);
      3'd3:    t = LFSR_W'(5'h17);
      3'd4:    t = LFSR_W'(5'h14);
      3'd5:    t = LFSR_W'(5'h12);
      default: t = LFSR_W'(5'h1E);
    endcase
    return t;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l,
                                                  input logic [LFSR_W-1:0] t);
    return {l[LFSR_W-2:0], ^(l & t)};
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] l,
                                                     input logic [LFSR_W-1:0] t,
                                                     input logic [7:0]        n);
    logic [LFSR_W-1:0] r;
    r = l;
    for (int j = 0; j < MAX_ADV; j++) begin
      if (8'(j) < n) begin
        r = lfsr_step(r, t);
      end
    end
    return r;
  endfunction

  // Memory ports: host owns both ports when mem_tb_control is high.
  // FSM writes are suppressed while init is held so an abort is immediate.
  assign mem_raddr = mem_tb_control ? raddr_tb   : fsm_raddr;
  assign mem_we    = mem_tb_control ? wr_en_tb   : (fsm_we & ~init);
  assign mem_waddr = mem_tb_control ? waddr_tb   : fsm_waddr;
  assign mem_wdata = mem_tb_control ? data_in_tb : fsm_wdata;

  dm1 dm1 (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  assign data_out_tb   = mem_rdata;
  assign done          = (state_q == ST_DONE);
  assign ks_byte       = {{(8 - LFSR_W){1'b0}}, lfsr_q};
  assign byte_match    = ((mem_rdata ^ ks_byte) == preamble);
  // Widened compares keep out-of-range pre_len values terminating.
  assign search_last   = (({1'b0, idx_q} + 9'd1) >= {1'b0, pre_len});
  assign decrypt_avail = ({1'b0, pre_len} < 9'(MSG_LEN));

`ifdef TAIL_FILL_EN
  logic tail_avail;
  assign tail_avail = (pre_len != 8'd0);
`endif

  // State and datapath registers; init clears everything except memory.
  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= ST_IDLE;
      lfsr_q  <= '0;
      seed_q  <= '0;
      pat_q   <= '0;
      idx_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
    end
  end

  // Next-state, LFSR sequencing and FSM memory port control.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    seed_d    = seed_q;
    pat_d     = pat_q;
    idx_d     = idx_q;
    k_d       = k_q;
    fsm_raddr = 8'd0;
    fsm_we    = 1'b0;
    fsm_waddr = 8'd0;
    fsm_wdata = 8'd0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_SEED;
      end

      ST_SEED: begin
        fsm_raddr = 8'd0;
        seed_d    = mem_rdata[LFSR_W-1:0] ^ preamble[LFSR_W-1:0];
        lfsr_d    = seed_d;
        pat_d     = 3'd0;
        idx_d     = 8'd0;
        k_d       = 8'd0;
        state_d   = ST_SEARCH;
      end

      ST_SEARCH: begin
        fsm_raddr = idx_q;
        if (byte_match) begin
          lfsr_d = lfsr_step(lfsr_q, taps_of(pat_q));
          if (search_last) begin
            // Pattern locked; LFSR now sits at position pre_len.
            idx_d   = pre_len;
            k_d     = 8'd0;
            state_d = decrypt_avail ? ST_DECRYPT : ST_DONE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else if (pat_q == 3'd5) begin
          // No pattern fits: fall back to pattern 0 positioned past the preamble.
          pat_d   = 3'd0;
          lfsr_d  = lfsr_advance(seed_q, taps_of(3'd0), pre_len);
          idx_d   = pre_len;
          k_d     = 8'd0;
          state_d = decrypt_avail ? ST_DECRYPT : ST_DONE;
        end else begin
          pat_d  = pat_q + 3'd1;
          lfsr_d = seed_q;
          idx_d  = 8'd0;
        end
      end

      ST_DECRYPT: begin
        fsm_raddr = idx_q;
        fsm_we    = 1'b1;
        fsm_waddr = 8'(OUT_BASE) + k_q;
        fsm_wdata = mem_rdata ^ ks_byte;
        lfsr_d    = lfsr_step(lfsr_q, taps_of(pat_q));
        idx_d     = idx_q + 8'd1;
        k_d       = k_q + 8'd1;
        if (idx_q == 8'(MSG_LEN - 1)) begin
`ifdef TAIL_FILL_EN
          state_d = tail_avail ? ST_TAIL : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end

`ifdef TAIL_FILL_EN
      ST_TAIL: begin
        fsm_we    = 1'b1;
        fsm_waddr = 8'(OUT_BASE) + k_q;
        fsm_wdata = preamble;
        k_d       = k_q + 8'd1;
        if (k_q == 8'(MSG_LEN - 1)) begin
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_decrypter_top_level.sv
`default_nettype none

module tb_decrypter_top_level;

  localparam int MSG_LEN = 64;

  logic       clk = 1'b0;
  logic       init;
  logic [7:0] preamble, pre_len;
  logic       wr_en_tb;
  logic [7:0] waddr_tb, data_in_tb, raddr_tb;
  logic [7:0] data_out_tb;
  logic       mem_tb_control;
  logic       done;

  always #5 clk = ~clk;

  decrypter_top_level dut (
    .clk            (clk),
    .init           (init),
    .preamble       (preamble),
    .pre_len        (pre_len),
    .wr_en_tb       (wr_en_tb),
    .waddr_tb       (waddr_tb),
    .data_in_tb     (data_in_tb),
    .raddr_tb       (raddr_tb),
    .data_out_tb    (data_out_tb),
    .mem_tb_control (mem_tb_control),
    .done           (done)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] mdl [256];   // expected memory image
  logic [7:0] pt  [64];    // plaintext block under construction
  int         exp_cycles;  // clock edges from init release until done=1
  int         cyc;
  bit         running = 1'b0;

  function automatic logic [4:0] tap(input int p);
    case (p)
      0: return 5'h1E;
      1: return 5'h1D;
      2: return 5'h1B;
      3: return 5'h17;
      4: return 5'h14;
      default: return 5'h12;
    endcase
  endfunction

  function automatic logic [4:0] stepf(input logic [4:0] l, input logic [4:0] t);
    return {l[3:0], ^(l & t)};
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Per-cycle comparison of done against the model's completion time.
  always @(negedge clk) begin
    if (running) begin
      cyc++;
      checks++;
      if (done !== (cyc >= exp_cycles)) begin
        errors++;
        $display("FAIL done_timing cycle %0d: got %0b expected %0b", cyc, done, (cyc >= exp_cycles));
      end
    end
  end

  task automatic host_write(input int a, input logic [7:0] d);
    @(negedge clk);
    mem_tb_control = 1'b1;
    wr_en_tb       = 1'b1;
    waddr_tb       = 8'(a);
    data_in_tb     = d;
    @(negedge clk);
    wr_en_tb       = 1'b0;
    mdl[a]         = d;
  endtask

  task automatic read_mem(input int a, output logic [7:0] d);
    mem_tb_control = 1'b1;
    raddr_tb       = 8'(a);
    #1;
    d = data_out_tb;
  endtask

  task automatic build_pt(input logic [7:0] pre, input int plen, input string msg);
    for (int i = 0; i < 64; i++) pt[i] = pre;
    for (int j = 0; j < msg.len(); j++) pt[plen + j] = msg[j];
  endtask

  task automatic encrypt_load(input int p, input logic [4:0] seed);
    logic [4:0] l;
    l = seed;
    for (int i = 0; i < 64; i++) begin
      host_write(i, pt[i] ^ {3'b000, l});
      l = stepf(l, tap(p));
    end
  endtask

  // Model: identify pattern from the preamble, decrypt, predict done time.
  task automatic model_run(input logic [7:0] pre, input int plen);
    logic [4:0] seed, l;
    logic [4:0] ks [64];
    int lock, s_cyc, bad, dec, tail;
    lock  = -1;
    s_cyc = 0;
    seed  = mdl[0][4:0] ^ pre[4:0];
    for (int p = 0; p < 6 && lock < 0; p++) begin
      l   = seed;
      bad = -1;
      for (int i = 0; i < plen && bad < 0; i++) begin
        if ((mdl[i] ^ {3'b000, l}) != pre) bad = i;
        l = stepf(l, tap(p));
      end
      if (bad < 0) begin
        lock  = p;
        s_cyc += plen;
      end else begin
        s_cyc += bad + 1;
      end
    end
    if (lock < 0) lock = 0;
    l = seed;
    for (int i = 0; i < 64; i++) begin
      ks[i] = l;
      l     = stepf(l, tap(lock));
    end
    dec = MSG_LEN - plen;
    for (int k = 0; k < dec; k++) mdl[64 + k] = mdl[plen + k] ^ {3'b000, ks[plen + k]};
    tail = 0;
`ifdef TAIL_FILL_EN
    for (int a = 64 + dec; a < 128; a++) mdl[a] = pre;
    tail = plen;
`endif
    exp_cycles = 2 + s_cyc + dec + tail;
  endtask

  task automatic start_run(input logic [7:0] pre, input int plen);
    preamble = pre;
    pre_len  = 8'(plen);
    model_run(pre, plen);
    @(negedge clk);
    mem_tb_control = 1'b0;
    @(negedge clk);
    init = 1'b0;
    #1;
    cyc     = 0;
    running = 1'b1;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got done=0 expected done=1 within 3000 cycles", name);
    end
    repeat (4) @(posedge clk);
    #1;
    running = 1'b0;
  endtask

  task automatic check_all(input string name);
    logic [7:0] d;
    for (int a = 0; a < 256; a++) begin
      read_mem(a, d);
      check8($sformatf("%s_mem[%0d]", name, a), d, mdl[a]);
    end
  endtask

  task automatic end_run();
    @(negedge clk);
    init = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string      nom_msg, long_msg;
    logic [7:0] d;

    nom_msg  = "Hey_Hamm_Look_Im_Picasso";
    long_msg = "The_quick_brown_fox_jumps_over_the_lazy_dog_123456";

    init = 1'b1; mem_tb_control = 1'b1; wr_en_tb = 1'b0;
    waddr_tb = 8'd0; data_in_tb = 8'd0; raddr_tb = 8'd0;
    preamble = 8'h7E; pre_len = 8'd9;

    repeat (3) @(negedge clk);
    check1("reset_done", done, 1'b0);

    for (int a = 0; a < 256; a++) host_write(a, 8'(a * 7 + 3));

    // Host write/read path.
    host_write(200, 8'hA5);
    read_mem(200, d);
    check8("host_rd_200", d, 8'hA5);

    // Nominal run, pattern 2, seed 0x01.
    build_pt(8'h7E, 9, nom_msg);
    encrypt_load(2, 5'h01);
    read_mem(0, d); check8("nom_ct0", d, 8'h7F);
    read_mem(1, d); check8("nom_ct1", d, 8'h7D);
    start_run(8'h7E, 9);
    wait_done("nominal");
    check_all("nominal");
    for (int j = 0; j < 24; j++) begin
      read_mem(64 + j, d);
      check8("nom_text", d, nom_msg[j]);
    end
    for (int a = 88; a < 119; a++) begin
      read_mem(a, d);
      check8("nom_pad", d, 8'h7E);
    end
    end_run();
    read_mem(200, d);
    check8("persist_200", d, 8'hA5);

    // Every pattern, seed 0x1F, pre_len 7.
    for (int p = 0; p < 6; p++) begin
      build_pt(8'h7E, 7, "");
      for (int i = 7; i < 64; i++) pt[i] = 8'(8'h30 + ((i * 5 + p * 3) % 70));
      encrypt_load(p, 5'h1F);
      start_run(8'h7E, 7);
      wait_done($sformatf("pat%0d", p));
      check_all($sformatf("pat%0d", p));
      end_run();
    end

    // pre_len 12, pattern 5, seed 0x15, 50-char message.
    build_pt(8'hA3, 12, long_msg);
    encrypt_load(5, 5'h15);
    start_run(8'hA3, 12);
    wait_done("len12");
    check_all("len12");
    read_mem(64, d);  check8("len12_first", d, 8'h54);
    read_mem(114, d); check8("len12_pad0", d, 8'hA3);
    read_mem(115, d); check8("len12_pad1", d, 8'hA3);
    end_run();

    // Abort mid-DECRYPT with a one-cycle init pulse, then rerun.
    build_pt(8'h7E, 9, nom_msg);
    encrypt_load(2, 5'h01);
    start_run(8'h7E, 9);
    repeat (exp_cycles - 20) @(posedge clk);
    #1;
    running = 1'b0;
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    check1("abort_done", done, 1'b0);
    init = 1'b0;
    #1;
    cyc     = 0;
    running = 1'b1;
    wait_done("rerun");
    check_all("rerun");
    end_run();

    // All-preamble plaintext, pattern 3, seed 0x0A.
    build_pt(8'h7E, 9, "");
    encrypt_load(3, 5'h0A);
    start_run(8'h7E, 9);
    wait_done("allpad");
    check_all("allpad");
    for (int a = 64; a < 119; a++) begin
      read_mem(a, d);
      check8("allpad_out", d, 8'h7E);
    end
`ifdef TAIL_FILL_EN
    for (int a = 119; a < 128; a++) begin
      read_mem(a, d);
      check8("allpad_tail", d, 8'h7E);
    end
`endif
    end_run();

    // No pattern matches: must fall back to pattern 0 and still finish.
    for (int i = 0; i < 64; i++) host_write(i, 8'($urandom_range(0, 255)));
    start_run(8'h7E, 7);
    wait_done("fallback");
    check_all("fallback");
    end_run();

    // Out-of-range pre_len still terminates.
    build_pt(8'h7E, 3, "Short_pre");
    encrypt_load(1, 5'h05);
    start_run(8'h7E, 3);
    wait_done("prelen3");
    check_all("prelen3");
    end_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
